// File: rtl/fft_pkg.sv
// Shared FFT types and helpers: reader FSM states, read-out latency, width clamp
// and the component/magnitude width helpers.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    localparam int RD_LATENCY = 3;

    // A pass is never narrower than 2 points nor wider than the RAM address space.
    function automatic logic [3:0] clamp_width(input logic [3:0] w, input int maw);
        logic [3:0] r;
        if (w == 4'd0) begin
            r = 4'd1;
        end else if (int'(w) > maw) begin
            r = 4'(maw);
        end else begin
            r = w;
        end
        return r;
    endfunction

    function automatic int word_width(input int dw);
        return 2 * dw;
    endfunction

    function automatic int mag_width(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/fft_mag_unit.sv
// Two-stage |re|,|im| -> magnitude pipeline with valid/bin/last sideband.
// FFT_MAG_AMBM_EN selects alpha-max-beta-min (3/8) instead of |re|+|im|.
module fft_mag_unit
    import fft_pkg::*;
#(
    parameter int MAW = 10,
    parameter int DW  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [MAW-1:0]            in_bin,
    input  logic                      in_last,
    input  logic [word_width(DW)-1:0] ram_q,
    output logic                      out_valid,
    output logic [MAW-1:0]            out_bin,
    output logic                      out_last,
    output logic [mag_width(DW)-1:0]  out_mag
);

    localparam int MW = mag_width(DW);

    // Two's complement magnitude; the most negative value maps to 2^(DW-1) unsigned.
    function automatic logic [DW-1:0] abs_c(input logic [DW-1:0] x);
        return x[DW-1] ? (~x + 1'b1) : x;
    endfunction

    logic           s1_valid_q, s1_valid_d;
    logic [MAW-1:0] s1_bin_q, s1_bin_d;
    logic           s1_last_q, s1_last_d;
    logic [DW-1:0]  s1_re_q, s1_re_d;
    logic [DW-1:0]  s1_im_q, s1_im_d;
    logic           out_valid_q, out_valid_d;
    logic [MAW-1:0] out_bin_q, out_bin_d;
    logic           out_last_q, out_last_d;
    logic [MW-1:0]  out_mag_q, out_mag_d;
`ifdef FFT_MAG_AMBM_EN
    logic [DW-1:0]  mx_s, mn_s;
`endif

    always_comb begin
        s1_valid_d  = in_valid;
        s1_bin_d    = in_bin;
        s1_last_d   = in_last;
        s1_re_d     = abs_c(ram_q[2*DW-1:DW]);
        s1_im_d     = abs_c(ram_q[DW-1:0]);
        out_valid_d = s1_valid_q;
        out_bin_d   = s1_bin_q;
        out_last_d  = s1_last_q;
`ifdef FFT_MAG_AMBM_EN
        if (s1_re_q >= s1_im_q) begin
            mx_s = s1_re_q;
            mn_s = s1_im_q;
        end else begin
            mx_s = s1_im_q;
            mn_s = s1_re_q;
        end
        out_mag_d = {1'b0, mx_s} + MW'(mn_s >> 2) + MW'(mn_s >> 3);
`else
        out_mag_d = {1'b0, s1_re_q} + {1'b0, s1_im_q};
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_bin_q    <= {MAW{1'b0}};
            s1_last_q   <= 1'b0;
            s1_re_q     <= {DW{1'b0}};
            s1_im_q     <= {DW{1'b0}};
            out_valid_q <= 1'b0;
            out_bin_q   <= {MAW{1'b0}};
            out_last_q  <= 1'b0;
            out_mag_q   <= {MW{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_bin_q    <= s1_bin_d;
            s1_last_q   <= s1_last_d;
            s1_re_q     <= s1_re_d;
            s1_im_q     <= s1_im_d;
            out_valid_q <= out_valid_d;
            out_bin_q   <= out_bin_d;
            out_last_q  <= out_last_d;
            out_mag_q   <= out_mag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign out_last  = out_last_q;
    assign out_mag   = out_mag_q;

endmodule

// File: rtl/fft_spectrum_reader.sv
// FFT read-out consumer: streams bins 0..N/2 with magnitudes and tracks the peak
// non-DC bin. Optional FFT_MAG_AMBM_EN picks the magnitude estimator in fft_mag_unit.
module fft_spectrum_reader
    import fft_pkg::*;
#(
    parameter int MAW = 10,
    parameter int DW  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_active,
    input  logic [MAW-1:0]            address_a,
    input  logic [3:0]                sel_addr_wth,
    input  logic [word_width(DW)-1:0] ram_q,
    output logic                      out_valid,
    output logic [MAW-1:0]            out_bin,
    output logic [mag_width(DW)-1:0]  out_mag,
    output logic                      out_last,
    output logic [MAW-1:0]            peak_bin,
    output logic [mag_width(DW)-1:0]  peak_mag,
    output logic                      done,
    output logic                      busy
);

    localparam int MW = mag_width(DW);

    rd_state_e      state_q, state_d;
    logic [3:0]     w_q, w_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           arm_q, arm_d;
    logic           inj_valid_q, inj_valid_d;
    logic           inj_last_q, inj_last_d;
    logic [MAW-1:0] inj_bin_q, inj_bin_d;
    logic [MAW-1:0] peak_bin_q, peak_bin_d;
    logic [MW-1:0]  peak_mag_q, peak_mag_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic           start_s, inject_s;
    logic [3:0]     w_eff_s;
    logic [MAW-1:0] half_s;

    // arm_q blocks a restart until rd_active has been seen low after a reset.
    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        cnt_d      = cnt_q;
        peak_bin_d = peak_bin_q;
        peak_mag_d = peak_mag_q;
        arm_d      = rd_active ? arm_q : 1'b1;
        start_s    = (state_q == IDLE) && rd_active && arm_q;
        inject_s   = start_s || ((state_q == RUN) && rd_active);
        w_eff_s    = (state_q == IDLE) ? clamp_width(sel_addr_wth, MAW) : w_q;
        half_s     = {{(MAW-1){1'b0}}, 1'b1} << (w_eff_s - 4'd1);
        inj_valid_d = inject_s && (address_a <= half_s);
        inj_last_d  = inject_s && (address_a == half_s);
        inj_bin_d   = address_a;

        if (out_valid && (out_bin != {MAW{1'b0}}) && (out_mag > peak_mag_q)) begin
            peak_bin_d = out_bin;
            peak_mag_d = out_mag;
        end else begin
            peak_bin_d = peak_bin_q;
            peak_mag_d = peak_mag_q;
        end

        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d    = RUN;
                    w_d        = clamp_width(sel_addr_wth, MAW);
                    peak_bin_d = {MAW{1'b0}};
                    peak_mag_d = {MW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!rd_active) begin
                    state_d = DRAIN;
                    cnt_d   = 2'd0;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (cnt_q == 2'(RD_LATENCY - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            w_q         <= 4'd0;
            cnt_q       <= 2'd0;
            arm_q       <= 1'b0;
            inj_valid_q <= 1'b0;
            inj_last_q  <= 1'b0;
            inj_bin_q   <= {MAW{1'b0}};
            peak_bin_q  <= {MAW{1'b0}};
            peak_mag_q  <= {MW{1'b0}};
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            cnt_q       <= cnt_d;
            arm_q       <= arm_d;
            inj_valid_q <= inj_valid_d;
            inj_last_q  <= inj_last_d;
            inj_bin_q   <= inj_bin_d;
            peak_bin_q  <= peak_bin_d;
            peak_mag_q  <= peak_mag_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    fft_mag_unit #(.MAW(MAW), .DW(DW)) u_mag (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inj_valid_q),
        .in_bin    (inj_bin_q),
        .in_last   (inj_last_q),
        .ram_q     (ram_q),
        .out_valid (out_valid),
        .out_bin   (out_bin),
        .out_last  (out_last),
        .out_mag   (out_mag)
    );

    assign peak_bin = peak_bin_q;
    assign peak_mag = peak_mag_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fft_spectrum_reader.sv
// Directed self-checking bench for fft_spectrum_reader with a one-cycle-latency RAM model.
module tb_fft_spectrum_reader;

    localparam int MAW = 10;
    localparam int DW  = 16;
`ifdef FFT_MAG_AMBM_EN
    localparam int EXP_EXT = 45056;
`else
    localparam int EXP_EXT = 65536;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_active;
    logic [9:0]  address_a;
    logic [3:0]  sel_addr_wth;
    logic [31:0] ram_q;
    logic        out_valid;
    logic [9:0]  out_bin;
    logic [16:0] out_mag;
    logic        out_last;
    logic [9:0]  peak_bin;
    logic [16:0] peak_mag;
    logic        done;
    logic        busy;

    logic signed [15:0] mem_re [0:1023];
    logic signed [15:0] mem_im [0:1023];

    logic        cap_v    [0:31];
    logic [9:0]  cap_bin  [0:31];
    logic [16:0] cap_mag  [0:31];
    logic        cap_last [0:31];
    logic        cap_done [0:31];
    logic        cap_busy [0:31];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= {mem_re[address_a], mem_im[address_a]};

    fft_spectrum_reader #(.MAW(MAW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_active    (rd_active),
        .address_a    (address_a),
        .sel_addr_wth (sel_addr_wth),
        .ram_q        (ram_q),
        .out_valid    (out_valid),
        .out_bin      (out_bin),
        .out_mag      (out_mag),
        .out_last     (out_last),
        .peak_bin     (peak_bin),
        .peak_mag     (peak_mag),
        .done         (done),
        .busy         (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) begin
            mem_re[i] = 16'sd0;
            mem_im[i] = 16'sd0;
        end
    endtask

    // Address t is driven at step t; its result is visible at step t+3.
    task automatic run_pass(input logic [3:0] s, input int nact);
        sel_addr_wth = s;
        for (int t = 0; t < nact + 8; t++) begin
            cap_v[t]    = out_valid;
            cap_bin[t]  = out_bin;
            cap_mag[t]  = out_mag;
            cap_last[t] = out_last;
            cap_done[t] = done;
            cap_busy[t] = busy;
            rd_active   = (t < nact);
            address_a   = (t < nact) ? 10'(t) : 10'd0;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rd_active = 1'b0; address_a = 10'd0; sel_addr_wth = 4'd4;
        clear_mem();
        for (int k = 0; k < 16; k++) mem_re[k] = 16'(k + 1);
        step(); step();
        n_checks++;
        if ({out_valid, out_bin, out_mag, out_last, peak_bin, peak_mag, done, busy} !== 58'd0)
            $display("FAIL reset_state: got valid=%b bin=%0d mag=%0d last=%b pk=%0d/%0d done=%b busy=%b, want all 0",
                     out_valid, out_bin, out_mag, out_last, peak_bin, peak_mag, done, busy);
        else n_pass++;
        rst = 1'b1; step(); step();
        for (int k = 0; k < 5; k++) begin
            rd_active = 1'b1; address_a = 10'(k); step();
        end
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_run: got %b want 1", busy);
        else n_pass++;
        rst = 1'b0;
        for (int k = 5; k < 7; k++) begin
            address_a = 10'(k); step();
            n_checks++;
            if ({out_valid, out_bin, out_mag, out_last, peak_bin, peak_mag, done, busy} !== 58'd0)
                $display("FAIL reset_mid: got valid=%b bin=%0d mag=%0d busy=%b, want all 0",
                         out_valid, out_bin, out_mag, busy);
            else n_pass++;
        end
        rst = 1'b1;
        for (int k = 7; k < 15; k++) begin
            address_a = 10'(k); step();
            n_checks++;
            if ({out_valid, busy, done} !== 3'b000)
                $display("FAIL no_restart: addr %0d got valid=%b busy=%b done=%b want 000", k, out_valid, busy, done);
            else n_pass++;
        end
        rd_active = 1'b0; step(); step(); step();
    endtask

    task automatic test_stream();
        int a;
        int em;
        logic ev;
        clear_mem();
        for (int k = 0; k < 16; k++) begin
            mem_re[k] = 16'(k);
            mem_im[k] = 16'(-k);
        end
        run_pass(4'd4, 16);
        for (int t = 0; t < 24; t++) begin
            a  = t - 3;
            ev = (a >= 0) && (a <= 8);
`ifdef FFT_MAG_AMBM_EN
            em = a + (a >> 2) + (a >> 3);
`else
            em = 2 * a;
`endif
            n_checks++;
            if (cap_v[t] !== ev) $display("FAIL stream_valid: step %0d got %b want %b", t, cap_v[t], ev);
            else n_pass++;
            if (ev) begin
                n_checks++;
                if (cap_bin[t] !== 10'(a) || cap_mag[t] !== 17'(em) || cap_last[t] !== (a == 8))
                    $display("FAIL stream_data: step %0d got bin=%0d mag=%0d last=%b want bin=%0d mag=%0d last=%b",
                             t, cap_bin[t], cap_mag[t], cap_last[t], a, em, (a == 8));
                else n_pass++;
            end
            n_checks++;
            if (cap_done[t] !== (t == 20) || cap_busy[t] !== (t >= 1 && t <= 20))
                $display("FAIL stream_ctrl: step %0d got done=%b busy=%b want done=%b busy=%b",
                         t, cap_done[t], cap_busy[t], (t == 20), (t >= 1 && t <= 20));
            else n_pass++;
        end
`ifdef FFT_MAG_AMBM_EN
        em = 11;
`else
        em = 16;
`endif
        n_checks++;
        if (peak_bin !== 10'd8 || peak_mag !== 17'(em))
            $display("FAIL stream_peak: got %0d/%0d want 8/%0d", peak_bin, peak_mag, em);
        else n_pass++;
    endtask

    task automatic test_extremes();
        clear_mem();
        mem_re[3] = 16'sh8000;
        mem_im[3] = 16'sh8000;
        run_pass(4'd4, 16);
        n_checks++;
        if (cap_v[6] !== 1'b1 || cap_bin[6] !== 10'd3 || cap_mag[6] !== 17'(EXP_EXT))
            $display("FAIL extreme_mag: got v=%b bin=%0d mag=%0d want 1/3/%0d", cap_v[6], cap_bin[6], cap_mag[6], EXP_EXT);
        else n_pass++;
        n_checks++;
        if (cap_mag[7] !== 17'd0) $display("FAIL extreme_next: got %0d want 0", cap_mag[7]);
        else n_pass++;
        n_checks++;
        if (peak_bin !== 10'd3 || peak_mag !== 17'(EXP_EXT))
            $display("FAIL extreme_peak: got %0d/%0d want 3/%0d", peak_bin, peak_mag, EXP_EXT);
        else n_pass++;
    endtask

    task automatic test_tie();
        clear_mem();
        for (int k = 0; k < 16; k++) mem_re[k] = 16'(k);
        mem_re[2]  = 16'sd100;
        mem_re[5]  = 16'sd0;
        mem_im[5]  = -16'sd100;
        mem_re[12] = 16'sd2000;
        run_pass(4'd4, 16);
        n_checks++;
        if (cap_mag[8] !== 17'd100) $display("FAIL tie_bin5: got %0d want 100", cap_mag[8]);
        else n_pass++;
        n_checks++;
        if (peak_bin !== 10'd2 || peak_mag !== 17'd100)
            $display("FAIL tie_peak: got %0d/%0d want 2/100", peak_bin, peak_mag);
        else n_pass++;
    endtask

    task automatic test_clamp();
        clear_mem();
        mem_re[0] = 16'sd500;
        mem_re[1] = 16'sd10;
        mem_re[2] = 16'sd300;
        mem_re[3] = 16'sd300;
        run_pass(4'd0, 4);
        n_checks++;
        if (cap_v[3] !== 1'b1 || cap_bin[3] !== 10'd0 || cap_mag[3] !== 17'd500 || cap_last[3] !== 1'b0)
            $display("FAIL clamp_dc: got v=%b bin=%0d mag=%0d last=%b want 1/0/500/0", cap_v[3], cap_bin[3], cap_mag[3], cap_last[3]);
        else n_pass++;
        n_checks++;
        if (cap_v[4] !== 1'b1 || cap_bin[4] !== 10'd1 || cap_mag[4] !== 17'd10 || cap_last[4] !== 1'b1)
            $display("FAIL clamp_bin1: got v=%b bin=%0d mag=%0d last=%b want 1/1/10/1", cap_v[4], cap_bin[4], cap_mag[4], cap_last[4]);
        else n_pass++;
        n_checks++;
        if (cap_v[5] !== 1'b0 || cap_v[6] !== 1'b0)
            $display("FAIL clamp_filter: got v5=%b v6=%b want 0 0", cap_v[5], cap_v[6]);
        else n_pass++;
        n_checks++;
        if (peak_bin !== 10'd1 || peak_mag !== 17'd10)
            $display("FAIL clamp_peak: got %0d/%0d want 1/10", peak_bin, peak_mag);
        else n_pass++;
    endtask

    task automatic test_abort();
        int nv;
        int nl;
        int nd;
        int em;
        clear_mem();
        for (int k = 0; k < 16; k++) begin
            mem_re[k] = 16'(k);
            mem_im[k] = 16'(-k);
        end
        run_pass(4'd4, 5);
        nv = 0; nl = 0; nd = 0;
        for (int t = 0; t < 13; t++) begin
            if (cap_v[t])    nv++;
            if (cap_last[t]) nl++;
            if (cap_done[t]) nd++;
        end
        n_checks++;
        if (nv !== 5) $display("FAIL abort_count: got %0d bins want 5", nv);
        else n_pass++;
        n_checks++;
        if (nl !== 0) $display("FAIL abort_last: got %0d want 0", nl);
        else n_pass++;
        n_checks++;
        if (nd !== 1 || cap_done[9] !== 1'b1) $display("FAIL abort_done: got %0d pulses, step9=%b want 1/1", nd, cap_done[9]);
        else n_pass++;
        n_checks++;
        if (cap_busy[12] !== 1'b0 || busy !== 1'b0) $display("FAIL abort_busy: got %b/%b want 0", cap_busy[12], busy);
        else n_pass++;
`ifdef FFT_MAG_AMBM_EN
        em = 5;
`else
        em = 8;
`endif
        n_checks++;
        if (peak_bin !== 10'd4 || peak_mag !== 17'(em))
            $display("FAIL abort_peak: got %0d/%0d want 4/%0d", peak_bin, peak_mag, em);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_extremes();
        test_tie();
        test_clamp();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
